clock_div_prog: RTL and testbench
=================================

Name: clock_div_prog

Overview:
- Multi-channel programmable clock divider.
- Each channel divides clk_in by a runtime-loadable integer ratio D with a 50% duty cycle for both even and odd D. Odd D uses a negedge half-cycle path.
- Ratio changes and enable/disable take effect only at period boundaries, so the output never glitches.
- Also emits a one-cycle strobe per period in the clk_in domain.
- Successor to the fixed /2, /4, /8, /16, /28 and /5 generators. Sits at the top of the clock_gen hierarchy and feeds downstream timing logic.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 8, width of each ratio and counter; maximum D = 2^CNT_W - 1.
- DEF_DIV, 2, per-channel ratio after reset; must be >= 2.

Ports:
- clk_in  input  1  source clock; all logic is on posedge except the odd-D negedge path.
- rst_n  input  1  asynchronous, active-low reset.
- div_val  input  NUM_CH*CNT_W  requested ratio; channel i uses bits [i*CNT_W +: CNT_W].
- load  input  NUM_CH  one-cycle pulse per channel; captures that channel's div_val slice.
- ch_en  input  NUM_CH  channel run enable, level-sensitive.
- clk_out  output  NUM_CH  divided clocks.
- strobe  output  NUM_CH  one clk_in-cycle pulse coincident with each clk_out rising edge.
- running  output  NUM_CH  high while the channel is actively dividing.
- div_err  output  NUM_CH  sticky flag: a load with div_val < 2 was rejected.

Behaviour:
Per channel state: div_q (active ratio), pend_q, pend_v, cnt (CNT_W bits), pos_q, neg_q, strobe_q, run_q, err_q.

Reset (asynchronous, rst_n = 0):
- div_q = DEF_DIV; cnt = DEF_DIV-1.
- pend_v, pos_q, neg_q, strobe_q, run_q, err_q = 0.
- All outputs 0.

High time H (in clk_in cycles):
- Even D: H = D/2.
- Odd D: H = (D-1)/2.

Posedge counter update:
- Counting: if cnt == div_q-1, cnt <= 0; otherwise cnt <= cnt+1.
- pos_q <= (cnt_next < H).
- strobe_q <= (cnt_next == 0).

Negedge path:
- neg_q <= pos_q when div_q is odd; otherwise neg_q <= 0.
- clk_out = pos_q | neg_q. For odd D this stretches the high phase by half a cycle to exactly D/2 periods.

Run/stop state machine (run_q):
- STOPPED: cnt is held at div_q-1, so clk_out = 0 and strobe = 0.
  - ch_en = 1 moves to RUN.
  - First posedge in RUN: cnt -> 0, clk_out rises, strobe = 1.
- RUN: counts as above.
  - ch_en = 0 is honoured only when cnt == div_q-1, i.e. the output is in its low phase. The counter then freezes there and the channel enters STOPPED.
  - No truncated high pulse is ever produced.
- running = run_q.

Ratio load:
- load[i] with div_val >= 2: pend_q <= div_val, pend_v <= 1.
- load[i] with div_val < 2: the load is ignored and err_q is set. err_q is cleared only by reset.
- Apply point, RUN: the wrap edge (cnt == div_q-1). On that edge div_q <= pend_q, pend_v <= 0, cnt <= 0, and H is recomputed from the new div_q for that edge.
- Apply point, STOPPED: the next posedge. div_q <= pend_q and cnt <= pend_q-1.
- A second load before the apply point overwrites pend_q; the last value wins.
- load and wrap on the same edge: the wrap applies the old pend_q if one was valid. The new value becomes pending for the next wrap.

Boundaries:
- D = 2 gives clk_out = clk_in/2 with strobe every second cycle.
- D = 2^CNT_W - 1: cnt must not overflow.
- ch_en toggled off then on within one period: no effect on the waveform.
- Reset mid-period: outputs drop to 0 immediately and asynchronously.

Channels are fully independent.

Optional Feature:
CLKDIV_SYNC_EN
- Defined: adds input port sync_in (1 bit).
  - A posedge sample of sync_in = 1 forces every RUN channel to cnt = div_q-1 and pos_q = 0 (neg_q follows at the negedge).
  - Pending ratios are applied at the same time.
  - Channels then restart together on the next edge, giving phase alignment.
  - The current high phase may be truncated; this is documented and accepted.
- Undefined: no sync_in port and no alignment logic.

Test Plan:
- Reset release, ch_en = 0001, DEF_DIV = 2 -> clk_out[0] toggles every clk_in cycle starting on the first edge, strobe[0] every 2nd cycle, other channels stay 0.
- load ch1 with D = 5, ch_en[1] = 1 -> clk_out[1] period 5 cycles, high exactly 2.5 cycles (negedge stretch), one strobe per period.
- Ch0 running D = 4, load D = 6 mid-period -> current 4-cycle period completes, then 6-cycle periods with 3 high; no glitch at the switch.
- Ch2 D = 8, drop ch_en at cnt = 1 -> high phase completes, output low, running falls at cnt = 7; re-enable -> rising edge on the next clk_in edge.
- load ch3 with div_val = 1 -> div_err[3] = 1, ratio unchanged; subsequent load of 3 -> applies normally, div_err[3] stays 1.
- Assert rst_n = 0 between clk_in edges while running -> all outputs 0 immediately; with CLKDIV_SYNC_EN, pulse sync_in on channels with D = 3 and D = 4 -> both rise on the same edge.

Source files
------------

// File: rtl/clock_div_prog.sv
// clock_div_prog: multi-channel programmable clock divider.
// Each channel divides clk_in by a runtime-loadable ratio D (2 .. 2^CNT_W-1)
// with a 50% duty cycle; odd D adds a half-cycle via a negedge flop.
// Ratio changes and stop requests only take effect at period boundaries.
//
// Ports:
//   clk_in   - source clock
//   rst_n    - asynchronous active-low reset
//   div_val  - requested ratio, channel i uses [i*CNT_W +: CNT_W]
//   load     - per-channel pulse capturing its div_val slice
//   ch_en    - per-channel run enable (level)
//   clk_out  - divided clocks
//   strobe   - one clk_in-cycle pulse at each clk_out rising edge
//   running  - channel actively dividing
//   div_err  - sticky: a load with div_val < 2 was rejected
//   sync_in  - (only with CLKDIV_SYNC_EN) realigns all running channels
//
// Optional feature macro: CLKDIV_SYNC_EN
module clock_div_prog #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       strobe,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       div_err
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic                    sync_in
`endif
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } run_state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_in;
    logic             pend_v_q, pend_v_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic             at_wrap;
    logic             boundary;
    logic             sync_hit;

    assign div_in  = div_val[i*CNT_W +: CNT_W];
    assign at_wrap = (cnt_q == div_q - ONE);

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync_in && (state_q == RUN);
`else
    assign sync_hit = 1'b0;
`endif

    // While stopped every edge is a boundary: the counter is parked at
    // div_q-1, so a start simply behaves like a normal wrap.
    assign boundary = (state_q == STOPPED) || at_wrap || sync_hit;

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= STOPPED;
        div_q    <= DEF;
        pend_q   <= DEF;
        pend_v_q <= 1'b0;
        cnt_q    <= DEF - ONE;
        pos_q    <= 1'b0;
        strobe_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        div_q    <= div_d;
        pend_q   <= pend_d;
        pend_v_q <= pend_v_d;
        cnt_q    <= cnt_d;
        pos_q    <= pos_d;
        strobe_q <= strobe_d;
        err_q    <= err_d;
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        STOPPED: if (ch_en[i]) state_d = RUN;
        RUN:     if (at_wrap && !ch_en[i]) state_d = STOPPED;
        default: state_d = STOPPED;
      endcase
    end

    always_comb begin
      div_d    = div_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      err_d    = err_q;

      // Apply uses the pending value from before this edge; a load on the
      // same edge becomes pending for the next boundary.
      if (boundary && pend_v_q) begin
        div_d    = pend_q;
        pend_v_d = 1'b0;
      end

      if (load[i]) begin
        if (div_in >= TWO) begin
          pend_d   = div_in;
          pend_v_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      if (!boundary) begin
        cnt_d = cnt_q + ONE;
      end else if ((state_d == RUN) && !sync_hit) begin
        cnt_d = '0;
      end else begin
        cnt_d = div_d - ONE;
      end

      // floor(D/2) is the posedge high time for both even and odd D.
      pos_d    = (cnt_d < (div_d >> 1));
      strobe_d = (cnt_d == '0);
    end

    always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= div_q[0] & pos_q;
    end

    assign clk_out[i] = pos_q | neg_q;
    assign strobe[i]  = strobe_q;
    assign running[i] = (state_q == RUN);
    assign div_err[i] = err_q;
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog: directed self-checking bench for clock_div_prog.
// Expected waveforms come from the rule that one period of D clk_in cycles
// holds clk_out high for exactly D half-cycles starting at its strobe edge.
// Optional macro CLKDIV_SYNC_EN adds the alignment checks.
module tb_clock_div_prog;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [31:0] div_val;
  logic [3:0]  load;
  logic [3:0]  ch_en;
  logic [3:0]  clk_out;
  logic [3:0]  strobe;
  logic [3:0]  running;
  logic [3:0]  div_err;
`ifdef CLKDIV_SYNC_EN
  logic        sync_in;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  clock_div_prog #(
    .NUM_CH (4),
    .CNT_W  (8),
    .DEF_DIV(2)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .div_val(div_val),
    .load   (load),
    .ch_en  (ch_en),
    .clk_out(clk_out),
    .strobe (strobe),
    .running(running),
    .div_err(div_err)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync_in(sync_in)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks one full period of channel ch with ratio d, starting at the next
  // posedge (the rising edge of the period).
  task automatic expect_period(input int unsigned ch, input int unsigned d, input string tag);
    for (int unsigned c = 0; c < d; c++) begin
      @(posedge clk_in); #1;
      check({tag, "_pos"}, 32'(clk_out[ch]), 32'(2 * c < d));
      check({tag, "_stb"}, 32'(strobe[ch]), 32'(c == 0));
      @(negedge clk_in); #1;
      check({tag, "_neg"}, 32'(clk_out[ch]), 32'(2 * c + 1 < d));
    end
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    rst_n   = 1'b0;
    div_val = '0;
    load    = '0;
    ch_en   = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif

    // reset held across an edge
    @(posedge clk_in); #1;
    check("rst_clk", 32'(clk_out), 32'(0));
    check("rst_stb", 32'(strobe), 32'(0));
    check("rst_run", 32'(running), 32'(0));
    check("rst_err", 32'(div_err), 32'(0));

    // ch0 default D=2 starts on first edge
    rst_n = 1'b1;
    ch_en = 4'b0001;
    for (int k = 0; k < 3; k++) expect_period(0, 2, "t1");
    check("t1_others", 32'(clk_out[3:1]), 32'(0));
    check("t1_run", 32'(running), 32'(4'b0001));

    // ch0 -> D=4 (pending across one D=2 period), then D=6 loaded mid-period
    div_val[7:0] = 8'd4;
    load = 4'b0001;
    fork
      expect_period(0, 2, "t3a");
      begin @(posedge clk_in); #2; load = '0; end
    join
    expect_period(0, 4, "t3b");
    fork
      expect_period(0, 4, "t3c");
      begin
        @(posedge clk_in); #2;
        div_val[7:0] = 8'd6;
        load = 4'b0001;
        @(posedge clk_in); #2;
        load = '0;
      end
    join
    expect_period(0, 6, "t3d");
    expect_period(0, 6, "t3e");

    // ch1 D=5 loaded while stopped, then enabled
    div_val[15:8] = 8'd5;
    load = 4'b0010;
    @(posedge clk_in); #1;
    load = '0;
    check("t2_run0", 32'(running[1]), 32'(0));
    @(posedge clk_in); #1;
    check("t2_clk0", 32'(clk_out[1]), 32'(0));
    check("t2_stb0", 32'(strobe[1]), 32'(0));
    ch_en = 4'b0011;
    expect_period(1, 5, "t2a");
    expect_period(1, 5, "t2b");
    check("t2_run1", 32'(running[1]), 32'(1));

    // ch1 maximum ratio
    div_val[15:8] = 8'd255;
    load = 4'b0010;
    fork
      expect_period(1, 5, "tmx0");
      begin @(posedge clk_in); #2; load = '0; end
    join
    expect_period(1, 255, "tmx1");
    expect_period(1, 255, "tmx2");

    // ch2 D=8, stop request at cnt=1
    div_val[23:16] = 8'd8;
    load = 4'b0100;
    @(posedge clk_in); #1;
    load = '0;
    @(posedge clk_in); #1;
    ch_en[2] = 1'b1;
    expect_period(2, 8, "t4a");
    fork
      expect_period(2, 8, "t4b");
      begin @(posedge clk_in); @(posedge clk_in); #2; ch_en[2] = 1'b0; end
    join
    check("t4_run_hold", 32'(running[2]), 32'(1));
    @(posedge clk_in); #1;
    check("t4_run_drop", 32'(running[2]), 32'(0));
    check("t4_clk_stop", 32'(clk_out[2]), 32'(0));
    check("t4_stb_stop", 32'(strobe[2]), 32'(0));
    @(posedge clk_in); #1;
    check("t4_clk_stop2", 32'(clk_out[2]), 32'(0));
    ch_en[2] = 1'b1;
    expect_period(2, 8, "t4c");
    // brief drop inside a period has no effect
    fork
      expect_period(2, 8, "t4d");
      begin
        @(posedge clk_in); #2; ch_en[2] = 1'b0;
        @(posedge clk_in); @(posedge clk_in); #2; ch_en[2] = 1'b1;
      end
    join
    expect_period(2, 8, "t4e");
    check("t4_run_on", 32'(running[2]), 32'(1));

    // ch3 illegal ratio then legal one
    div_val[31:24] = 8'd1;
    load = 4'b1000;
    @(posedge clk_in); #1;
    load = '0;
    check("t5_err", 32'(div_err), 32'(4'b1000));
    ch_en[3] = 1'b1;
    expect_period(3, 2, "t5a");
    div_val[31:24] = 8'd3;
    load = 4'b1000;
    fork
      expect_period(3, 2, "t5b");
      begin @(posedge clk_in); #2; load = '0; end
    join
    expect_period(3, 3, "t5c");
    expect_period(3, 3, "t5d");
    check("t5_err_sticky", 32'(div_err), 32'(4'b1000));

    // asynchronous reset mid high phase
    @(posedge clk_in); #2;
    check("t6_pre_clk", 32'(clk_out[3]), 32'(1));
    check("t6_pre_stb", 32'(strobe[3]), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t6_clk", 32'(clk_out), 32'(0));
    check("t6_stb", 32'(strobe), 32'(0));
    check("t6_run", 32'(running), 32'(0));
    check("t6_err", 32'(div_err), 32'(0));
    #2;
    rst_n = 1'b1;
    ch_en = '0;
    @(posedge clk_in); #1;
    check("t6_idle", 32'(clk_out), 32'(0));

`ifdef CLKDIV_SYNC_EN
    // ch0 D=3, ch1 D=4 started a cycle apart, then aligned by sync_in
    div_val[7:0]  = 8'd3;
    div_val[15:8] = 8'd4;
    load = 4'b0011;
    @(posedge clk_in); #1;
    load = '0;
    @(posedge clk_in); #1;
    ch_en = 4'b0001;
    @(posedge clk_in); #1;
    ch_en = 4'b0011;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    sync_in = 1'b1;
    @(posedge clk_in); #1;
    sync_in = 1'b0;
    check("ts_stb", 32'(strobe[1:0]), 32'(0));
    @(negedge clk_in); #1;
    check("ts_clk", 32'(clk_out[1:0]), 32'(0));
    fork
      expect_period(0, 3, "ts0");
      expect_period(1, 4, "ts1");
    join
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
